imem_loader: RTL and testbench

- Boot-time writer for the instruction memory that the single-cycle core fetches from.
- Accepts a byte stream over a valid/ready handshake: a 4-byte word count, then the program words, then an XOR checksum byte.
- Assembles little-endian 32-bit words and issues one write per word at consecutive byte addresses.
- Holds the core in reset until the image is loaded and its checksum has verified.

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/loader_word_pack.sv | 43 ++++
 rtl/imem_loader.sv | 154 +++++++++++++++
 tb/tb_imem_loader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
package imem_loader_pkg;

    localparam int LEN_BYTES  = 4;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHK   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    function automatic logic accepts_bytes(input state_t s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/loader_word_pack.sv
// Packs stream bytes little-endian into a word and keeps the running XOR checksum.
module loader_word_pack
    import imem_loader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             byte_en,
    input  logic [7:0]       byte_data,
    output logic [WIDTH-1:0] word,
    output logic             word_full,
    output logic [7:0]       chk
);

    logic [1:0]       r_lane;
    logic [WIDTH-1:0] r_word;
    logic [7:0]       r_chk;

    // Lane counter, shift-in assembly register and checksum accumulator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lane <= 2'd0;
            r_word <= {WIDTH{1'b0}};
            r_chk  <= 8'd0;
        end else if (clear) begin
            r_lane <= 2'd0;
            r_word <= {WIDTH{1'b0}};
            r_chk  <= 8'd0;
        end else if (byte_en) begin
            r_lane <= r_lane + 2'd1;
            // Shifting in from the top leaves the first byte in bits 7:0.
            r_word <= {byte_data, r_word[WIDTH-1:8]};
            r_chk  <= r_chk ^ byte_data;
        end
    end

    assign word      = r_word;
    assign word_full = byte_en && (r_lane == 2'(WORD_BYTES - 1));
    assign chk       = r_chk;

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, checksummed image into instruction memory and releases the core.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int               MAX_WORDS = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             core_reset_n,
    output logic             done,
    output logic             error
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_WORDS);

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_len_cnt;
    logic [WIDTH-1:0] r_len;
    logic [WIDTH-1:0] r_idx;
    logic             r_byte_ready;
    logic             r_mem_we;
    logic [WIDTH-1:0] r_mem_addr;
    logic             r_done;
    logic             r_error;
    logic             r_core_reset_n;

    logic             w_fire;
    logic             w_start_ok;
    logic [WIDTH-1:0] w_len_next;
    logic             w_len_last;
    logic             w_len_bad;
    logic             w_word_full;
    logic [7:0]       w_chk;
    logic [WIDTH-1:0] w_word;

    assign w_fire     = byte_valid && r_byte_ready;
    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
    assign w_len_next = {byte_data, r_len[WIDTH-1:8]};
    assign w_len_last = w_fire && (r_state == ST_LEN) && (r_len_cnt == 2'(LEN_BYTES - 1));
    assign w_len_bad  = (w_len_next == {WIDTH{1'b0}}) || (w_len_next > MAX_W);

    loader_word_pack #(.WIDTH(WIDTH)) u_pack (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_start_ok),
        .byte_en   (w_fire && (r_state == ST_DATA)),
        .byte_data (byte_data),
        .word      (w_word),
        .word_full (w_word_full),
        .chk       (w_chk)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_LEN;
                else       w_next = ST_IDLE;
            end
            ST_LEN: begin
                if (w_len_last) w_next = w_len_bad ? ST_ERR : ST_DATA;
                else            w_next = ST_LEN;
            end
            ST_DATA: begin
                if (w_word_full) w_next = ST_WRITE;
                else             w_next = ST_DATA;
            end
            ST_WRITE: begin
                if ((r_idx + WIDTH'(1)) == r_len) w_next = ST_CHK;
                else                              w_next = ST_DATA;
            end
            ST_CHK: begin
                if (w_fire) w_next = (byte_data == w_chk) ? ST_DONE : ST_ERR;
                else        w_next = ST_CHK;
            end
            ST_DONE, ST_ERR: begin
                if (start) w_next = ST_LEN;
                else       w_next = r_state;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Length capture and word index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len_cnt <= 2'd0;
            r_len     <= {WIDTH{1'b0}};
            r_idx     <= {WIDTH{1'b0}};
        end else if (w_start_ok) begin
            r_len_cnt <= 2'd0;
            r_len     <= {WIDTH{1'b0}};
            r_idx     <= {WIDTH{1'b0}};
        end else begin
            if ((r_state == ST_LEN) && w_fire) begin
                r_len_cnt <= r_len_cnt + 2'd1;
                r_len     <= w_len_next;
            end
            if (r_state == ST_WRITE) begin
                r_idx <= r_idx + WIDTH'(1);
            end
        end
    end

    // Outputs are decoded from the next state so they change together with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_byte_ready   <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= BASE_ADDR;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_core_reset_n <= 1'b0;
        end else begin
            r_byte_ready   <= accepts_bytes(w_next);
            r_mem_we       <= (w_next == ST_WRITE);
            if (w_next == ST_WRITE) begin
                r_mem_addr <= BASE_ADDR + (r_idx << 2);
            end
            r_done         <= (w_next == ST_DONE);
            r_error        <= (w_next == ST_ERR);
            r_core_reset_n <= (w_next == ST_DONE);
        end
    end

    assign byte_ready   = r_byte_ready;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = w_word;
    assign core_reset_n = r_core_reset_n;
    assign done         = r_done;
    assign error        = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as words are streamed.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_reset_n;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;
    int writes_seen = 0;
    int writes_pushed = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [7:0]  chk_model;
    int          widx;

    imem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .core_reset_n (core_reset_n),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    // Write monitor: every mem_we pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b1 && mem_we === 1'b1) begin
            logic [31:0] ea;
            logic [31:0] ed;
            writes_seen++;
            total++;
            if (q_addr.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", mem_addr, mem_wdata);
            end else begin
                ea = q_addr.pop_front();
                ed = q_data.pop_front();
                if (mem_addr !== ea || mem_wdata !== ed) begin
                    bad++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h", mem_addr, mem_wdata, ea, ed);
                end
            end
            total++;
            if (byte_ready !== 1'b0) begin
                bad++;
                $display("FAIL ready_in_write: got byte_ready=%b, required 0", byte_ready);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got byte_ready=%b after %0d cycles, required 1", byte_ready, n);
        end
        tick();
        byte_valid = 1'b0;
        byte_data  = 8'h00;
    endtask

    task automatic begin_load(input logic [31:0] len);
        chk_model = 8'h00;
        widx      = 0;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = len[8*i +: 8];
            send_byte(b);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = w[8*i +: 8];
            chk_model = chk_model ^ b;
            if (i == 3) begin
                q_addr.push_back(32'h0000_0000 + 32'(4 * widx));
                q_data.push_back(w);
                writes_pushed++;
            end
            send_byte(b);
            if (i < 3) repeat (gap) tick();
        end
        widx++;
        total++;
        if (mem_we !== 1'b1 || byte_ready !== 1'b0) begin
            bad++;
            $display("FAIL write_cycle: got mem_we=%b byte_ready=%b, required 1/0", mem_we, byte_ready);
        end
        if (gap > 0) begin
            tick();
            total++;
            if (mem_we !== 1'b0 || byte_ready !== 1'b1) begin
                bad++;
                $display("FAIL after_write: got mem_we=%b byte_ready=%b, required 0/1", mem_we, byte_ready);
            end
            repeat (gap - 1) tick();
        end
    endtask

    task automatic check_idle_outputs(input string name);
        total++;
        if (byte_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
            core_reset_n !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            bad++;
            $display("FAIL %s: got rdy=%b we=%b addr=%h wdata=%h crn=%b done=%b err=%b, required all zero",
                     name, byte_ready, mem_we, mem_addr, mem_wdata, core_reset_n, done, error);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        #23;
        check_idle_outputs("reset_values");
        reset = 1'b1;
        byte_valid = 1'b1; byte_data = 8'hAA;
        repeat (3) tick();
        byte_valid = 1'b0;
        check_idle_outputs("idle_holds");
    endtask

    task automatic test_single();
        chk_model = 8'h00;
        widx = 0;
        pulse_start();
        total++;
        if (byte_ready !== 1'b1) begin
            bad++;
            $display("FAIL len_ready: got %b, required 1", byte_ready);
        end
        send_byte(8'h01);
        send_byte(8'h00);
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        send_word(32'h00A0_0513, 0);
        total++;
        if (core_reset_n !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL pre_chk: got crn=%b done=%b, required 0/0", core_reset_n, done);
        end
        send_byte(chk_model);
        total++;
        if (core_reset_n !== 1'b1 || done !== 1'b1 || error !== 1'b0 || byte_ready !== 1'b0) begin
            bad++;
            $display("FAIL single_done: got crn=%b done=%b err=%b rdy=%b, required 1/1/0/0",
                     core_reset_n, done, error, byte_ready);
        end
    endtask

    task automatic test_back_to_back_gaps();
        pulse_start();
        total++;
        if (done !== 1'b0 || core_reset_n !== 1'b0) begin
            bad++;
            $display("FAIL restart_done: got done=%b crn=%b, required 0/0", done, core_reset_n);
        end
        chk_model = 8'h00;
        widx = 0;
        send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_word(32'h1111_1111, 2);
        send_word(32'h2222_2222, 2);
        send_word(32'h3333_3333, 2);
        send_byte(chk_model);
        total++;
        if (done !== 1'b1 || core_reset_n !== 1'b1) begin
            bad++;
            $display("FAIL multi_done: got done=%b crn=%b, required 1/1", done, core_reset_n);
        end
    endtask

    task automatic test_bad_len(input logic [31:0] len, input string name);
        begin_load(len);
        total++;
        if (error !== 1'b1 || core_reset_n !== 1'b0 || done !== 1'b0 || byte_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s: got err=%b crn=%b done=%b rdy=%b, required 1/0/0/0",
                     name, error, core_reset_n, done, byte_ready);
        end
        byte_valid = 1'b1; byte_data = 8'h55;
        repeat (3) tick();
        byte_valid = 1'b0;
    endtask

    task automatic test_bad_checksum();
        pulse_start();
        total++;
        if (error !== 1'b0) begin
            bad++;
            $display("FAIL restart_err: got err=%b, required 0", error);
        end
        chk_model = 8'h00;
        widx = 0;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_word(32'h00A0_0513, 0);
        send_byte(8'hFF);
        total++;
        if (error !== 1'b1 || done !== 1'b0 || core_reset_n !== 1'b0) begin
            bad++;
            $display("FAIL bad_chk: got err=%b done=%b crn=%b, required 1/0/0", error, done, core_reset_n);
        end
        begin_load(32'd1);
        send_word(32'h00A0_0513, 0);
        send_byte(chk_model);
        total++;
        if (done !== 1'b1 || error !== 1'b0 || core_reset_n !== 1'b1) begin
            bad++;
            $display("FAIL retry_done: got done=%b err=%b crn=%b, required 1/0/1", done, error, core_reset_n);
        end
    endtask

    task automatic test_async_reset();
        begin_load(32'd1);
        send_byte(8'h13);
        send_byte(8'h05);
        #3;
        reset = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        repeat (2) tick();
        check_idle_outputs("reset_held");
        #3;
        reset = 1'b1;
        tick();
        begin_load(32'd2);
        send_word(32'hDEAD_BEEF, 1);
        send_word(32'h0102_0304, 0);
        send_byte(chk_model);
        total++;
        if (done !== 1'b1 || core_reset_n !== 1'b1) begin
            bad++;
            $display("FAIL reload_done: got done=%b crn=%b, required 1/1", done, core_reset_n);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back_gaps();
        test_bad_len(32'd0, "len_zero");
        test_bad_len(32'd257, "len_257");
        test_bad_checksum();
        test_async_reset();
        repeat (3) tick();
        total++;
        if (q_addr.size() != 0 || writes_seen != writes_pushed) begin
            bad++;
            $display("FAIL write_count: got seen=%0d pending=%0d, required seen=%0d pending=0",
                     writes_seen, q_addr.size(), writes_pushed);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
